conway_gen_ctrl: RTL and testbench



---
 rtl/conway_pkg.sv | 17 +
 rtl/conway_row_sel.sv | 28 ++
 rtl/conway_gen_ctrl.sv | 153 +++++++++++++++
 tb/tb_conway_gen_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conway_pkg.sv
// Shared definitions for the Life generation controller: state encoding and the
// row-slice helper used wherever a row is picked out of the flat board vector.
package conway_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_LOAD = 2'd1;
   localparam state_t ST_RUN  = 2'd2;
   localparam state_t ST_DUMP = 2'd3;

   // Row r lives at bits [row_lsb(r, width) +: width] of the board vector.
   function automatic int row_lsb(input int row, input int width);
      return row * width;
   endfunction

endpackage

// File: rtl/conway_row_sel.sv
// Row read mux for readout and one-hot row write-enable decode for loading,
// both driven by the controller's shared row index.
module conway_row_sel
   import conway_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int HEIGHT = 32,
   parameter int IDX_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
)(
   input  logic [WIDTH*HEIGHT-1:0] i_board,
   input  logic [IDX_W-1:0]        i_idx,
   input  logic                    i_wr_en,
   output logic [WIDTH-1:0]        o_row,
   output logic [HEIGHT-1:0]       o_wr_onehot
);

   always_comb begin
      o_row       = '0;
      o_wr_onehot = '0;
      for (int r = 0; r < HEIGHT; r++) begin
         if (i_idx == IDX_W'(r)) begin
            o_row          = i_board[row_lsb(r, WIDTH) +: WIDTH];
            o_wr_onehot[r] = i_wr_en;
         end
      end
   end

endmodule

// File: rtl/conway_gen_ctrl.sv
// Generation controller: owns the board register, loads/dumps it row by row and
// steps or free-runs generations. CONWAY_STILL_DETECT_EN adds still-life halt in RUN.
module conway_gen_ctrl
   import conway_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int HEIGHT = 32,
   parameter int GEN_W  = 16
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [WIDTH-1:0]        load_row,
   input  logic                    cmd_step,
   input  logic                    cmd_run,
   input  logic                    cmd_stop,
   input  logic                    cmd_dump,
   output logic [WIDTH*HEIGHT-1:0] cur_states,
   input  logic [WIDTH*HEIGHT-1:0] next_states,
   output logic [GEN_W-1:0]        gen_count,
   output logic                    busy,
   output logic                    stable,
   output logic                    rd_valid,
   input  logic                    rd_ready,
   output logic [WIDTH-1:0]        rd_row,
   output logic                    rd_last
);

   localparam int             IDX_W    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HEIGHT - 1);

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [WIDTH*HEIGHT-1:0] r_board;
   logic [GEN_W-1:0]        r_gen;
   logic [IDX_W-1:0]        r_idx;
   logic                    w_load_fire;
   logic                    w_rd_fire;
   logic                    w_idx_last;
   logic                    w_still;
   logic [WIDTH-1:0]        w_sel_row;
   logic [HEIGHT-1:0]       w_wr_onehot;

   conway_row_sel #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .IDX_W(IDX_W)) u_row_sel (
      .i_board     (r_board),
      .i_idx       (r_idx),
      .i_wr_en     (w_load_fire),
      .o_row       (w_sel_row),
      .o_wr_onehot (w_wr_onehot)
   );

   assign w_load_fire = load_valid & load_ready;
   assign w_rd_fire   = rd_valid & rd_ready;
   assign w_idx_last  = (r_idx == LAST_IDX);
   assign cur_states  = r_board;
   assign gen_count   = r_gen;

`ifdef CONWAY_STILL_DETECT_EN
   logic r_stable;
   assign w_still = (next_states == r_board);
   assign stable  = r_stable;

   always_ff @(posedge clk) begin
      if (rst)
         r_stable <= 1'b0;
      else if (r_state == ST_RUN && !cmd_stop && w_still)
         r_stable <= 1'b1;
      else if ((r_state == ST_IDLE && !w_load_fire && !cmd_dump && (cmd_step || cmd_run)) ||
               (r_state == ST_LOAD && w_load_fire && w_idx_last))
         r_stable <= 1'b0;
   end
`else
   assign w_still = 1'b0;
   assign stable  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_load_fire)   w_state_nxt = ST_LOAD;
            else if (cmd_dump) w_state_nxt = ST_DUMP;
            else if (cmd_step) w_state_nxt = ST_IDLE;
            else if (cmd_run)  w_state_nxt = ST_RUN;
         end
         ST_LOAD: if (w_load_fire && w_idx_last)  w_state_nxt = ST_IDLE;
         ST_RUN:  if (cmd_stop || w_still)        w_state_nxt = ST_IDLE;
         ST_DUMP: if (w_rd_fire && w_idx_last)    w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      load_ready = (r_state == ST_IDLE) || (r_state == ST_LOAD);
      busy       = (r_state != ST_IDLE);
      rd_valid   = (r_state == ST_DUMP);
      rd_row     = rd_valid ? w_sel_row : '0;
      rd_last    = rd_valid && w_idx_last;
   end

   // Row index is always 0 in IDLE, so the first load beat lands in row 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_board <= '0;
         r_gen   <= '0;
         r_idx   <= '0;
      end else begin
         for (int r = 0; r < HEIGHT; r++)
            if (w_wr_onehot[r]) r_board[row_lsb(r, WIDTH) +: WIDTH] <= load_row;
         case (r_state)
            ST_IDLE: begin
               if (w_load_fire) begin
                  r_idx <= IDX_W'(1);
               end else if (cmd_dump) begin
                  r_idx <= '0;
               end else if (cmd_step) begin
                  r_board <= next_states;
                  r_gen   <= r_gen + GEN_W'(1);
               end
            end
            ST_LOAD: begin
               if (w_load_fire) begin
                  if (w_idx_last) begin
                     r_idx <= '0;
                     r_gen <= '0;
                  end else begin
                     r_idx <= r_idx + IDX_W'(1);
                  end
               end
            end
            ST_RUN: begin
               if (!cmd_stop && !w_still) begin
                  r_board <= next_states;
                  r_gen   <= r_gen + GEN_W'(1);
               end
            end
            ST_DUMP: begin
               if (w_rd_fire) r_idx <= w_idx_last ? '0 : r_idx + IDX_W'(1);
            end
            default: r_idx <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_conway_gen_ctrl.sv
// Self-checking bench for conway_gen_ctrl on an 8x8 board; the Life next-state
// function is modelled here and also feeds the controller's next_states input.
module tb_conway_gen_ctrl;

   localparam int W = 8;
   localparam int H = 8;
   localparam int G = 16;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           load_valid = 1'b0;
   logic           load_ready;
   logic [W-1:0]   load_row = '0;
   logic           cmd_step = 1'b0;
   logic           cmd_run = 1'b0;
   logic           cmd_stop = 1'b0;
   logic           cmd_dump = 1'b0;
   logic [W*H-1:0] cur_states;
   logic [W*H-1:0] next_states;
   logic [G-1:0]   gen_count;
   logic           busy;
   logic           stable;
   logic           rd_valid;
   logic           rd_ready = 1'b0;
   logic [W-1:0]   rd_row;
   logic           rd_last;

   int n_cmp = 0;
   int n_bad = 0;

   logic [63:0] m_board;
   logic [15:0] m_gen;
   logic        m_stable;

   always #5 clk = ~clk;

   conway_gen_ctrl #(.WIDTH(W), .HEIGHT(H), .GEN_W(G)) dut (
      .clk(clk), .rst(rst),
      .load_valid(load_valid), .load_ready(load_ready), .load_row(load_row),
      .cmd_step(cmd_step), .cmd_run(cmd_run), .cmd_stop(cmd_stop), .cmd_dump(cmd_dump),
      .cur_states(cur_states), .next_states(next_states),
      .gen_count(gen_count), .busy(busy), .stable(stable),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_row(rd_row), .rd_last(rd_last)
   );

   // B3/S23 with border cells forced dead.
   function automatic logic [63:0] life(input logic [63:0] b);
      logic [63:0] n;
      int cnt;
      n = '0;
      for (int r = 1; r < H - 1; r++) begin
         for (int c = 1; c < W - 1; c++) begin
            cnt = 0;
            for (int dr = -1; dr <= 1; dr++)
               for (int dc = -1; dc <= 1; dc++)
                  if (dr != 0 || dc != 0) cnt += int'(b[(r + dr) * W + c + dc]);
            n[r * W + c] = (cnt == 3) || (cnt == 2 && b[r * W + c]);
         end
      end
      return n;
   endfunction

   always_comb next_states = life(cur_states);

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input string tag);
      check({tag, ".board"}, cur_states, m_board);
      check({tag, ".gen"}, 64'(gen_count), 64'(m_gen));
      check({tag, ".stable"}, 64'(stable), 64'(m_stable));
      check({tag, ".busy"}, 64'(busy), 64'd0);
   endtask

   task automatic load_board(input logic [63:0] b);
      for (int r = 0; r < H; r++) begin
         load_valid = 1'b1;
         load_row   = b[r * W +: W];
         tick();
      end
      load_valid = 1'b0;
      m_board  = b;
      m_gen    = '0;
      m_stable = 1'b0;
   endtask

   task automatic do_step();
      cmd_step = 1'b1;
      tick();
      cmd_step = 1'b0;
      m_board  = life(m_board);
      m_gen    = m_gen + 16'd1;
      m_stable = 1'b0;
   endtask

   // Pulse cmd_run, let k cycles pass, then pulse cmd_stop.
   task automatic do_run(input int k);
      logic [63:0] nb;
      bit running;
      cmd_run = 1'b1;
      tick();
      cmd_run  = 1'b0;
      m_stable = 1'b0;
      running  = 1'b1;
      for (int i = 0; i < k; i++) begin
         if (running) begin
            nb = life(m_board);
`ifdef CONWAY_STILL_DETECT_EN
            if (nb == m_board) begin
               m_stable = 1'b1;
               running  = 1'b0;
            end else begin
               m_board = nb;
               m_gen   = m_gen + 16'd1;
            end
`else
            m_board = nb;
            m_gen   = m_gen + 16'd1;
`endif
         end
         tick();
      end
      cmd_stop = 1'b1;
      tick();
      cmd_stop = 1'b0;
   endtask

   task automatic do_dump(input bit rand_ready);
      int e;
      int k;
      cmd_dump = 1'b1;
      tick();
      cmd_dump = 1'b0;
      e = 0;
      k = 0;
      while (e < H && k < 200) begin
         rd_ready = rand_ready ? 1'($urandom_range(0, 1)) : ((k % 4 == 0) || (k % 4 == 3));
         check("dump.valid", 64'(rd_valid), 64'd1);
         check("dump.row", 64'(rd_row), 64'(m_board[e * W +: W]));
         check("dump.last", 64'(rd_last), 64'(e == H - 1));
         if (rd_ready) e++;
         k++;
         tick();
      end
      rd_ready = 1'b0;
      check("dump.rows_done", 64'(e), 64'(H));
      check("dump.valid_end", 64'(rd_valid), 64'd0);
      check("dump.busy_end", 64'(busy), 64'd0);
   endtask

   initial begin
      logic [63:0] b;
      logic [63:0] blinker;
      logic [63:0] glider;
      logic [63:0] glider_shift;
      logic [63:0] blk;

      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("rst.board", cur_states, 64'd0);
      check("rst.gen", 64'(gen_count), 64'd0);
      check("rst.busy", 64'(busy), 64'd0);
      check("rst.load_ready", 64'(load_ready), 64'd1);
      check("rst.rd_valid", 64'(rd_valid), 64'd0);
      check("rst.rd_row", 64'(rd_row), 64'd0);
      check("rst.rd_last", 64'(rd_last), 64'd0);
      check("rst.stable", 64'(stable), 64'd0);

      // Blinker
      blinker = '0;
      blinker[3 * W +: W] = 8'b0001_1100;
      load_board(blinker);
      check_model("blinker.load");
      do_step();
      check("blinker.r2", 64'(cur_states[2 * W +: W]), 64'h08);
      check("blinker.r3", 64'(cur_states[3 * W +: W]), 64'h08);
      check("blinker.r4", 64'(cur_states[4 * W +: W]), 64'h08);
      check("blinker.gen1", 64'(gen_count), 64'd1);
      check_model("blinker.step1");
      do_step();
      check("blinker.back", cur_states, blinker);
      check("blinker.gen2", 64'(gen_count), 64'd2);

      // Block still life
      blk = '0;
      blk[3 * W +: W] = 8'b0001_1000;
      blk[4 * W +: W] = 8'b0001_1000;
      load_board(blk);
      cmd_run = 1'b1;
      tick();
      cmd_run = 1'b0;
      check("block.busy_run", 64'(busy), 64'd1);
      tick();
`ifdef CONWAY_STILL_DETECT_EN
      check("block.busy", 64'(busy), 64'd0);
      check("block.stable", 64'(stable), 64'd1);
      check("block.gen", 64'(gen_count), 64'd0);
`else
      tick();
      tick();
      check("block.busy", 64'(busy), 64'd1);
      check("block.gen", 64'(gen_count), 64'd3);
      cmd_stop = 1'b1;
      tick();
      cmd_stop = 1'b0;
      check("block.stopped", 64'(busy), 64'd0);
      check("block.gen_stop", 64'(gen_count), 64'd3);
      check("block.board", cur_states, blk);
`endif

      // Glider moves (+1,+1) every 4 generations
      glider = '0;
      glider[2 * W +: W] = 8'b0000_1000;
      glider[3 * W +: W] = 8'b0001_0000;
      glider[4 * W +: W] = 8'b0001_1100;
      glider_shift = '0;
      glider_shift[3 * W +: W] = 8'b0001_0000;
      glider_shift[4 * W +: W] = 8'b0010_0000;
      glider_shift[5 * W +: W] = 8'b0011_1000;
      load_board(glider);
      do_run(4);
      check("glider.gen", 64'(gen_count), 64'd4);
      check("glider.board", cur_states, glider_shift);
      check_model("glider");

      // Dump with 1,0,0,1 ready pattern
      do_dump(1'b0);
      check("dump.board_kept", cur_states, glider_shift);

      // Reset mid-load
      for (int r = 0; r < 3; r++) begin
         load_valid = 1'b1;
         load_row   = 8'hA5 ^ 8'(r);
         tick();
      end
      load_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rstload.board", cur_states, 64'd0);
      check("rstload.busy", 64'(busy), 64'd0);
      check("rstload.load_ready", 64'(load_ready), 64'd1);
      load_valid = 1'b1;
      load_row   = 8'h3C;
      tick();
      load_valid = 1'b0;
      check("rstload.row0", 64'(cur_states[W-1:0]), 64'h3C);
      check("rstload.row1", 64'(cur_states[W +: W]), 64'h00);

      // Finish that load, then load beat racing cmd_step in IDLE
      b = '0;
      b[0 +: W] = 8'h3C;
      for (int r = 1; r < H; r++) begin
         load_valid = 1'b1;
         load_row   = b[r * W +: W];
         tick();
      end
      load_valid = 1'b0;
      m_board = b; m_gen = '0; m_stable = 1'b0;
      do_step();
      check_model("race.pre");
      b = m_board;
      load_valid = 1'b1;
      cmd_step   = 1'b1;
      load_row   = 8'h81;
      tick();
      cmd_step   = 1'b0;
      load_valid = 1'b0;
      check("race.gen", 64'(gen_count), 64'd1);
      check("race.row0", 64'(cur_states[W-1:0]), 64'h81);
      check("race.rest", 64'(cur_states[63:W]), 64'(b[63:W]));
      check("race.busy", 64'(busy), 64'd1);
      b[W-1:0] = 8'h81;
      for (int r = 1; r < H; r++) begin
         load_valid = 1'b1;
         load_row   = b[r * W +: W];
         tick();
      end
      load_valid = 1'b0;
      m_board = b; m_gen = '0; m_stable = 1'b0;
      check_model("race.done");

      // Randomized sessions against the model
      for (int it = 0; it < 6; it++) begin
         b = {$urandom, $urandom};
         load_board(b);
         check_model("rand.load");
         for (int s = 0; s < int'($urandom_range(0, 3)); s++) do_step();
         check_model("rand.step");
         do_run(int'($urandom_range(0, 10)));
         check_model("rand.run");
         do_dump(1'b1);
         check_model("rand.dump");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
